// File: rtl/perf_counter_bank_if.sv
// Control, event-strobe and readout bundle shared by perf_counter_bank and its driver.
interface perf_counter_bank_if #(
    parameter int NCH = 4,
    parameter int CW  = 32,
    parameter int SW  = 3
);
    logic           start;
    logic           halt;
    logic           clr;
    logic [NCH-1:0] evt;
    logic           snap;
    logic           rd_src;
    logic [SW-1:0]  sel;
    logic [CW-1:0]  rd_data;
    logic [NCH:0]   ovf;
    logic [1:0]     state;

    modport master (
        output start, halt, clr, evt, snap, rd_src, sel,
        input  rd_data, ovf, state
    );

    modport slave (
        input  start, halt, clr, evt, snap, rd_src, sel,
        output rd_data, ovf, state
    );
endinterface

// File: rtl/perf_counter_bank.sv
// Performance counter bank: one cycle counter plus NCH event counters with shadow snapshot and sticky overflow.
// Define PERF_SAT_EN to make counters saturate at all-ones instead of wrapping.
module perf_counter_bank #(
    parameter int NCH = 4,
    parameter int CW  = 32,
    parameter int SW  = 3
) (
    input logic                clk,
    input logic                rst,
    perf_counter_bank_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_HALTED = 2'b10
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_live   [NCH+1];
    logic [CW-1:0] r_shadow [NCH+1];
    logic [NCH:0]  r_ovf;
    logic [CW-1:0] r_rdData;

    logic [NCH:0]  w_inc;
    logic [SW-1:0] w_sel;
    logic [CW-1:0] w_readVal;

    assign w_sel = bus.sel;

    // Index 0 is the cycle counter, so it counts on every RUN cycle.
    always_comb begin
        w_inc = '0;
        if (r_state == S_RUN) begin
            w_inc = {bus.evt, 1'b1};
        end
    end

    // An index past the last channel matches nothing and reads as zero.
    always_comb begin
        w_readVal = '0;
        for (int k = 0; k <= NCH; k++) begin
            if (int'(w_sel) == k) begin
                w_readVal = bus.rd_src ? r_shadow[k] : r_live[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (bus.clr) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (bus.start) r_state <= S_RUN;
                S_RUN:    if (bus.halt)  r_state <= S_HALTED;
                S_HALTED: r_state <= S_HALTED;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Shadows capture the pre-increment, pre-clear values and survive clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= NCH; k++) begin
                r_live[k]   <= '0;
                r_shadow[k] <= '0;
            end
            r_ovf <= '0;
        end else begin
            if (bus.snap) begin
                for (int k = 0; k <= NCH; k++) begin
                    r_shadow[k] <= r_live[k];
                end
            end
            if (bus.clr) begin
                for (int k = 0; k <= NCH; k++) begin
                    r_live[k] <= '0;
                end
                r_ovf <= '0;
            end else begin
                for (int k = 0; k <= NCH; k++) begin
                    if (w_inc[k]) begin
                        if (r_live[k] == '1) begin
                            r_ovf[k] <= 1'b1;
`ifdef PERF_SAT_EN
                            r_live[k] <= '1;
`else
                            r_live[k] <= '0;
`endif
                        end else begin
                            r_live[k] <= r_live[k] + CW'(1);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdData <= '0;
        end else begin
            r_rdData <= w_readVal;
        end
    end

    assign bus.rd_data = r_rdData;
    assign bus.ovf     = r_ovf;
    assign bus.state   = r_state;
endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter NCH, default 4: number of event counter channels, legal range 1..16.
REQ-002 Parameter CW, default 32: width of every counter, legal range 8..64.
REQ-003 Parameter SW, default 3: select width, SHALL satisfy 2^SW >= NCH+1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  level; begins counting when in IDLE.
REQ-007 halt  input  1  level; CPU halt indication (syscall exit), ends counting.
REQ-008 clr  input  1  synchronous clear of counters and overflow flags; returns to IDLE.
REQ-009 evt  input  NCH  per-channel event strobes (branch, branch-taken, jump, ...), one count per high cycle.
REQ-010 snap  input  1  pulse; copies all live counters into shadow registers.
REQ-011 rd_src  input  1  readout source: 0 = live, 1 = shadow.
REQ-012 sel  input  SW  readout index: 0 = cycle counter, k = event channel k-1.
REQ-013 rd_data  output  CW  registered readout value.
REQ-014 ovf  output  NCH+1  sticky overflow flags; bit 0 = cycle counter, bit k = channel k-1.
REQ-015 state  output  2  FSM state: 00 IDLE, 01 RUN, 10 HALTED.

Function
REQ-016 FSM transitions: IDLE->RUN when start=1; RUN->HALTED when halt=1; HALTED->IDLE only on clr=1; any state->IDLE on clr=1.
REQ-017 clr SHALL take priority over start and halt in the same cycle; the next state SHALL be IDLE and all counters SHALL be 0.
REQ-018 The cycle counter SHALL increment by 1 in every cycle the FSM is in RUN, including the cycle in which halt=1.
REQ-019 Event counter i SHALL increment by 1 in every RUN cycle with evt[i]=1, including the halt cycle; evt SHALL be ignored in IDLE and HALTED.
REQ-020 halt=1 in IDLE SHALL be ignored; start=1 in RUN or HALTED SHALL be ignored.
REQ-021 Counter overflow (all-ones, incremented) SHALL wrap to 0 and set the matching ovf bit, which holds until clr or rst.
REQ-022 snap=1 SHALL load every shadow register with the current live value (the pre-increment, pre-clear value of that cycle); shadows are unaffected by clr.
REQ-023 rd_data SHALL equal the selected live or shadow register value as sampled at the previous rising edge (latency 1 cycle from sel/rd_src).
REQ-024 When sel > NCH, rd_data SHALL be 0 on the next cycle.
REQ-025 All counter arithmetic SHALL be unsigned, CW bits; no carry is exposed except through ovf.

Reset
REQ-026 rst=1 SHALL immediately, without a clock edge, force state=IDLE, all live counters, shadows, rd_data and ovf to 0.
REQ-027 rst asserted mid-RUN SHALL discard all counts; counting resumes only after rst=0 and a new start.

Configuration
REQ-028 Macro PERF_SAT_EN: when defined, a counter at all-ones SHALL hold at all-ones on further increments (saturate) and set its ovf bit; when undefined, the counter SHALL wrap per REQ-021.

Verification
REQ-029 NCH=4, CW=8: rst, start for 1 cycle, halt high on 10th RUN cycle -> cycle counter 10, state=HALTED, later evt pulses leave counts unchanged.
REQ-030 CW=8: evt[1] high for 300 RUN cycles -> channel 1 reads 44, ovf[2]=1; with PERF_SAT_EN -> reads 255, ovf[2]=1.
REQ-031 snap while channel 0 = 5 and evt[0]=1 -> shadow sel=1 reads 5, live sel=1 reads 6.
REQ-032 clr and start asserted together in HALTED -> state=IDLE, all live counters and ovf 0, shadows unchanged.
REQ-033 rst asserted asynchronously mid-RUN with counts nonzero -> state, rd_data, ovf 0 before next clk edge.
REQ-034 NCH=4, sel=7 -> rd_data=0 one cycle later; sel=0 -> cycle counter value one cycle later.
